// File: rtl/nfu1_zo_pkg.sv
// nfu1_zo_pkg: shared decode types and index helpers for the NFU-1 zero-replacement window
package nfu1_zo_pkg;
  typedef struct packed {
    logic       in_range;
    logic       is_current;
    logic [3:0] d;
    logic [7:0] off;
  } sel_dec_t;

  function automatic int num_cands(input int nd, input int nw);
    return nd * (nw + 1);
  endfunction

  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

  function automatic int slot_lo(input int slot, input int lane, input int tn, input int bw);
    return (slot * tn + lane) * bw;
  endfunction

  // Out-of-range selects leave d/off at zero so downstream indexing stays in bounds
  function automatic sel_dec_t sel_decode(input logic [15:0] s, input int nd, input int nw);
    sel_dec_t r;
    int c;
    r = '0;
    c = int'(s) - 1;
    if (s == '0) begin
      r.in_range   = 1'b1;
      r.is_current = 1'b1;
    end else if (int'(s) <= num_cands(nd, nw)) begin
      r.in_range = 1'b1;
      r.d        = 4'(c / (nw + 1));
      r.off      = 8'(c % (nw + 1));
    end
    return r;
  endfunction
endpackage

// File: rtl/nfu1_zo_lane_mux.sv
// nfu1_zo_lane_mux: per-lane candidate selection from the current brick or the history window
module nfu1_zo_lane_mux import nfu1_zo_pkg::*; #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int D         = 2,
  parameter int W         = 3,
  parameter int SEL_WIDTH = 4,
  parameter int LANE      = 0
) (
  input  logic [BIT_WIDTH-1:0]      cur_i,
  input  logic [D*Tn*BIT_WIDTH-1:0] hist_i,
  input  logic [D-1:0]              hv_i,
  input  logic [SEL_WIDTH-1:0]      sel_i,
  output logic [BIT_WIDTH-1:0]      val_o,
  output logic                      repl_o,
  output logic                      err_o
);
  sel_dec_t             dec;
  logic [D-1:0]         hv_sh;
  logic                 hit;
  logic [BIT_WIDTH-1:0] cand;

  always_comb begin
    dec    = sel_decode(16'(sel_i), D, W);
    hv_sh  = hv_i >> dec.d;
    hit    = dec.in_range && !dec.is_current && hv_sh[0];
    cand   = hist_i[slot_lo(int'(dec.d), (LANE + int'(dec.off)) % Tn, Tn, BIT_WIDTH) +: BIT_WIDTH];
    val_o  = dec.is_current ? cur_i : hit ? cand : '0;
    repl_o = hit;
    err_o  = !dec.in_range;
  end
endmodule

// File: rtl/nfu1_zero_repl_window.sv
// nfu1_zero_repl_window: parametrised zero-replacement front end feeding the NFU-1 multiplier array
module nfu1_zero_repl_window import nfu1_zo_pkg::*; #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int D         = 2,
  parameter int W         = 3,
  parameter int SEL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [BIT_WIDTH*Tn-1:0]   i_inputs,
  input  logic [SEL_WIDTH*Tn-1:0]   i_sel_lines,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [BIT_WIDTH*Tn-1:0]   o_inputs,
  output logic                      o_sel_err,
  output logic [15:0]               o_repl_count
);
  localparam int NUM_CANDS = num_cands(D, W);
  localparam int TB        = BIT_WIDTH * Tn;
  localparam int CW        = $clog2(Tn + 1);

  if (NUM_CANDS > 2**SEL_WIDTH - 1) begin : g_bad_cfg
    $error("D*(W+1) does not fit in SEL_WIDTH select bits");
  end

  logic [D*TB-1:0] hist_q, hist_d;
  logic [D-1:0]    hv_q, hv_d, hv_eff;
  logic [TB-1:0]   out_q, mux_val;
  logic            out_v_q, err_q, acc;
  logic [15:0]     cnt_q, cnt_d;
  logic [Tn-1:0]   repl, err;
  logic [CW-1:0]   pop;
  logic [16:0]     sum;

  assign o_ready = !out_v_q || i_ready;
  assign acc     = i_valid && o_ready;
  assign hv_eff  = i_flush ? '0 : hv_q;

  for (genvar l = 0; l < Tn; l++) begin : g_lane
    nfu1_zo_lane_mux #(
      .BIT_WIDTH(BIT_WIDTH), .Tn(Tn), .D(D), .W(W), .SEL_WIDTH(SEL_WIDTH), .LANE(l)
    ) u_mux (
      .cur_i (i_inputs[lane_lo(l, BIT_WIDTH) +: BIT_WIDTH]),
      .hist_i(hist_q),
      .hv_i  (hv_eff),
      .sel_i (i_sel_lines[lane_lo(l, SEL_WIDTH) +: SEL_WIDTH]),
      .val_o (mux_val[lane_lo(l, BIT_WIDTH) +: BIT_WIDTH]),
      .repl_o(repl[l]),
      .err_o (err[l])
    );
  end

  // History shift reads the flush-masked valid bits so a flush+accept leaves only slot 0 valid
  always_comb begin
    pop = '0;
    for (int l = 0; l < Tn; l++) pop = pop + CW'(repl[l]);
    sum    = 17'(cnt_q) + 17'(pop);
    cnt_d  = sum[16] ? 16'hFFFF : sum[15:0];
    hist_d = hist_q;
    hv_d   = hv_eff;
    if (acc) begin
      for (int k = D - 1; k > 0; k--) begin
        hist_d[k*TB +: TB] = hist_q[(k-1)*TB +: TB];
        hv_d[k]            = hv_eff[k-1];
      end
      hist_d[TB-1:0] = i_inputs;
      hv_d[0]        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      hv_q    <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      hv_q    <= hv_d;
      out_v_q <= acc || (out_v_q && !i_ready);
      if (acc) begin
        out_q <= mux_val;
        err_q <= |err;
        cnt_q <= cnt_d;
      end
    end
  end

  assign o_valid      = out_v_q;
  assign o_inputs     = out_q;
  assign o_sel_err    = err_q;
  assign o_repl_count = cnt_q;
endmodule
